// File: rtl/demux4bit_pkg.sv
// Shared constants and types for the registered 1-to-2 4-bit demultiplexer.
// The optional per-channel pop counters are enabled with DEMUX4BIT_CNT_EN.
package demux4bit_pkg;

  localparam int DEMUX_WIDTH = 4;
  localparam int DEMUX_DEPTH = 2;
  localparam int DEMUX_CNT_W = 8;

  typedef logic [DEMUX_WIDTH-1:0] demux_word_t;

endpackage

// File: rtl/demux4bit_reg_if.sv
// Handshake bus of demux4bit_reg: one upstream valid/ready port, two downstream channels.
// The slave side is the demux itself; the master side is its environment.
interface demux4bit_reg_if #(
  parameter int WIDTH = demux4bit_pkg::DEMUX_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic             s;
  logic [WIDTH-1:0] d;
  logic             f0_valid;
  logic             f0_ready;
  logic [WIDTH-1:0] f0;
  logic             f1_valid;
  logic             f1_ready;
  logic [WIDTH-1:0] f1;

  modport master (
    output in_valid, s, d, f0_ready, f1_ready,
    input  in_ready, f0_valid, f0, f1_valid, f1
  );

  modport slave (
    input  in_valid, s, d, f0_ready, f1_ready,
    output in_ready, f0_valid, f0, f1_valid, f1
  );

endinterface

// File: rtl/demux_chan_fifo.sv
// One output channel of the demux: a DEPTH-entry FIFO with valid/ready pop side.
// With DEMUX4BIT_CNT_EN an 8-bit wrapping count of popped words is also kept.
module demux_chan_fifo
  import demux4bit_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH,
  parameter int DEPTH = DEMUX_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop_ready,
  output logic             valid,
  output logic [WIDTH-1:0] dout
`ifdef DEMUX4BIT_CNT_EN
  ,
  output logic [DEMUX_CNT_W-1:0] cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] last_q;
  logic             do_push;
  logic             do_pop;

  assign valid   = (count != '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = valid && pop_ready;

  // An empty FIFO keeps presenting the word it last handed out (0 after reset).
  assign dout = valid ? mem[rd_ptr] : last_q;

  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        last_q <= mem[rd_ptr];
      end
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CW'(1);
      end
    end
  end

`ifdef DEMUX4BIT_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (do_pop) begin
      cnt <= cnt + DEMUX_CNT_W'(1);
    end
  end
`endif

endmodule

// File: rtl/demux4bit_reg.sv
// Registered 1-to-2 demultiplexer: steers each accepted word into channel 0 or 1 by s.
// Each channel buffers independently; DEMUX4BIT_CNT_EN adds cnt0/cnt1 pop counters.
module demux4bit_reg
  import demux4bit_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH,
  parameter int DEPTH = DEMUX_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  demux4bit_reg_if.slave  bus
`ifdef DEMUX4BIT_CNT_EN
  ,
  output logic [DEMUX_CNT_W-1:0] cnt0,
  output logic [DEMUX_CNT_W-1:0] cnt1
`endif
);

  logic full0;
  logic full1;
  logic push0;
  logic push1;

  // Readiness depends only on the selected channel, never on downstream readies.
  assign bus.in_ready = bus.s ? !full1 : !full0;
  assign push0        = bus.in_valid && bus.in_ready && !bus.s;
  assign push1        = bus.in_valid && bus.in_ready &&  bus.s;

  demux_chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_chan0 (
    .clk       (clk),
    .rst       (rst),
    .push      (push0),
    .din       (bus.d),
    .full      (full0),
    .pop_ready (bus.f0_ready),
    .valid     (bus.f0_valid),
    .dout      (bus.f0)
`ifdef DEMUX4BIT_CNT_EN
    ,
    .cnt       (cnt0)
`endif
  );

  demux_chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_chan1 (
    .clk       (clk),
    .rst       (rst),
    .push      (push1),
    .din       (bus.d),
    .full      (full1),
    .pop_ready (bus.f1_ready),
    .valid     (bus.f1_valid),
    .dout      (bus.f1)
`ifdef DEMUX4BIT_CNT_EN
    ,
    .cnt       (cnt1)
`endif
  );

endmodule

// File: tb/tb_demux4bit_reg.sv
// Scoreboard bench for demux4bit_reg: directed sequences plus random traffic.
// Builds with or without DEMUX4BIT_CNT_EN; counters are checked when present.
module tb_demux4bit_reg;
  import demux4bit_pkg::*;

  localparam int DEPTH = DEMUX_DEPTH;

  logic clk;
  logic rst;

  demux4bit_reg_if #(.WIDTH(DEMUX_WIDTH)) bus ();

`ifdef DEMUX4BIT_CNT_EN
  logic [DEMUX_CNT_W-1:0] cnt0;
  logic [DEMUX_CNT_W-1:0] cnt1;
`endif

  demux4bit_reg #(.WIDTH(DEMUX_WIDTH), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus)
`ifdef DEMUX4BIT_CNT_EN
    ,
    .cnt0 (cnt0),
    .cnt1 (cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared;
  int mismatched;

  // Reference: each channel is an ordered list of words waiting to be consumed.
  demux_word_t q0[$];
  demux_word_t q1[$];
  int          occ0;
  int          occ1;
  int          pops0;
  int          pops1;
  logic        zero0;
  logic        zero1;

  task automatic checkOutput(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of stimulus and advances the reference model at the clock edge.
  task automatic applyStimulus(input logic v, input logic sel, input demux_word_t data,
                               input logic r0, input logic r1, input logic rs);
    logic pop0, pop1, acc;
    rst          = rs;
    bus.in_valid = v;
    bus.s        = sel;
    bus.d        = data;
    bus.f0_ready = r0;
    bus.f1_ready = r1;
    @(posedge clk);
    if (rs) begin
      q0.delete();
      q1.delete();
      occ0  = 0;
      occ1  = 0;
      pops0 = 0;
      pops1 = 0;
      zero0 = 1'b1;
      zero1 = 1'b1;
    end else begin
      pop0 = (occ0 > 0) && r0;
      pop1 = (occ1 > 0) && r1;
      acc  = v && ((sel ? occ1 : occ0) < DEPTH);
      if (pop0) begin occ0--; pops0++; end
      if (pop1) begin occ1--; pops1++; end
      if (acc && !sel) begin q0.push_back(data); occ0++; zero0 = 1'b0; end
      if (acc &&  sel) begin q1.push_back(data); occ1++; zero1 = 1'b0; end
    end
    #1;
  endtask

  // Monitor: compares the DUT against the scoreboard away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) continue;
      checkOutput("in_ready", int'(bus.in_ready),
                  int'(((bus.s ? occ1 : occ0) < DEPTH)));
      checkOutput("f0_valid", int'(bus.f0_valid), int'(q0.size() != 0));
      checkOutput("f1_valid", int'(bus.f1_valid), int'(q1.size() != 0));
      if (q0.size() != 0) checkOutput("f0_data", int'(bus.f0), int'(q0[0]));
      else if (zero0)     checkOutput("f0_reset_data", int'(bus.f0), 0);
      if (q1.size() != 0) checkOutput("f1_data", int'(bus.f1), int'(q1[0]));
      else if (zero1)     checkOutput("f1_reset_data", int'(bus.f1), 0);
`ifdef DEMUX4BIT_CNT_EN
      checkOutput("cnt0", int'(cnt0), pops0 % 256);
      checkOutput("cnt1", int'(cnt1), pops1 % 256);
`endif
      if (q0.size() != 0 && bus.f0_ready) void'(q0.pop_front());
      if (q1.size() != 0 && bus.f1_ready) void'(q1.pop_front());
    end
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    occ0 = 0; occ1 = 0; pops0 = 0; pops1 = 0;
    zero0 = 1'b1; zero1 = 1'b1;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.s = 1'b0; bus.d = '0;
    bus.f0_ready = 1'b0; bus.f1_ready = 1'b0;

    $display("[TB] reset");
    applyStimulus(0, 0, 4'h0, 0, 0, 1);
    applyStimulus(0, 0, 4'h0, 0, 0, 1);
    applyStimulus(0, 0, 4'h0, 0, 0, 0);

    $display("[TB] sweep channel 0");
    for (int i = 0; i < 16; i++) applyStimulus(1, 0, demux_word_t'(i), 1, 0, 0);
    applyStimulus(0, 0, 4'h0, 1, 0, 0);

    $display("[TB] sweep channel 1");
    for (int i = 0; i < 16; i++) applyStimulus(1, 1, demux_word_t'(i), 0, 1, 0);
    applyStimulus(0, 1, 4'h0, 0, 1, 0);

    $display("[TB] stall channel 0");
    applyStimulus(1, 0, 4'b0011, 0, 0, 0);
    applyStimulus(1, 0, 4'b0101, 0, 0, 0);
    applyStimulus(1, 0, 4'b1111, 0, 0, 0);
    applyStimulus(0, 1, 4'h0, 0, 0, 0);
    applyStimulus(0, 0, 4'h0, 1, 0, 0);
    applyStimulus(0, 0, 4'h0, 1, 0, 0);
    applyStimulus(0, 0, 4'h0, 1, 0, 0);

    $display("[TB] interleave");
    applyStimulus(1, 0, 4'b0001, 1, 1, 0);
    applyStimulus(1, 1, 4'b0010, 1, 1, 0);
    applyStimulus(1, 0, 4'b0011, 1, 1, 0);
    applyStimulus(1, 1, 4'b0100, 1, 1, 0);
    applyStimulus(0, 0, 4'h0, 1, 1, 0);

    $display("[TB] fill both then reset");
    applyStimulus(1, 0, 4'hA, 0, 0, 0);
    applyStimulus(1, 0, 4'hB, 0, 0, 0);
    applyStimulus(1, 1, 4'hC, 0, 0, 0);
    applyStimulus(1, 1, 4'hD, 0, 0, 0);
    applyStimulus(1, 1, 4'hE, 1, 1, 1);
    applyStimulus(0, 0, 4'h0, 0, 0, 0);
    applyStimulus(0, 1, 4'h0, 0, 0, 0);

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom % 4) != 0, 1'($urandom), 4'($urandom),
                    ($urandom % 3) != 0, ($urandom % 3) != 0,
                    ($urandom % 200) == 0);
    end

`ifdef DEMUX4BIT_CNT_EN
    $display("[TB] counter wrap on channel 1");
    applyStimulus(0, 0, 4'h0, 0, 0, 1);
    for (int i = 0; i < 257; i++) applyStimulus(1, 1, 4'($urandom), 0, 1, 0);
    applyStimulus(0, 1, 4'h0, 0, 1, 0);
    checkOutput("cnt1_after_257", int'(cnt1), 1);
    checkOutput("cnt0_after_257", int'(cnt0), 0);
`endif

    applyStimulus(0, 0, 4'h0, 1, 1, 0);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
